// File: rtl/tdm_demux16_pkg.sv
// Shared constants and state encoding for the TDM slot demultiplexer.
// Vectors are MSB-first [0:N-1]: bit 0 corresponds to sel/slot 0.
package tdm_pkg;

  localparam int SLOTS = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux16_dec.sv
// Select index to one-hot write-enable decoder; the inverse of the 16:1 mux tree.
// Purely combinational, no backpressure.
module dec4to16_onehot #(
  parameter int SLOTS = tdm_pkg::SLOTS,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic [0:SEL_W-1] sel,
  output logic [0:SLOTS-1] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux16.sv
// Reassembles a serial TDM slot stream into a parallel word, or writes single addressed bits.
// Latency 1 cycle to out/out_valid; no backpressure, every valid input bit is consumed.
module tdm_demux16 import tdm_pkg::*; #(
  parameter int SLOTS = tdm_pkg::SLOTS,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  input  logic             mode,
  input  logic [0:SEL_W-1] sel_in,
  output logic [0:SLOTS-1] out,
  output logic             out_valid,
  output logic [0:SEL_W-1] slot,
  output logic             frame_err
);

  state_t           state, state_n;
  logic [0:SEL_W-1] slot_n;
  logic [0:SLOTS-1] staging, staging_n;
  logic [0:SLOTS-1] out_n;
  logic             out_valid_n;
  logic             frame_err_n;

  logic [0:SEL_W-1] wsel;
  logic [0:SLOTS-1] we;
  logic [0:SLOTS-1] wr_bits;

  // Both modes share one decoder: the slot counter in auto-scan, sel_in when addressed.
  assign wsel    = mode ? sel_in : slot;
  assign wr_bits = {SLOTS{din}} & we;

  dec4to16_onehot #(
    .SLOTS (SLOTS),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (wsel),
    .onehot (we)
  );

  always_comb begin
    state_n     = state;
    slot_n      = slot;
    staging_n   = staging;
    out_n       = out;
    out_valid_n = 1'b0;
    frame_err_n = 1'b0;

    if (mode) begin
      state_n   = HUNT;
      slot_n    = '0;
      staging_n = '0;
      if (din_valid) begin
        out_n       = (out & ~we) | wr_bits;
        out_valid_n = 1'b1;
      end
    end else if (din_valid) begin
      if (sync) begin
        // A sync anywhere but slot 0 of a running frame is early: flag it, restart here.
        frame_err_n  = (state == RUN) && (slot != '0);
        staging_n    = '0;
        staging_n[0] = din;
        slot_n       = SEL_W'(1);
        state_n      = RUN;
      end else if (state == RUN) begin
        if (slot == '0) begin
          frame_err_n = 1'b1;
          state_n     = HUNT;
        end else if (slot == SEL_W'(SLOTS-1)) begin
          out_n       = (staging & ~we) | wr_bits;
          out_valid_n = 1'b1;
          slot_n      = '0;
        end else begin
          staging_n = (staging & ~we) | wr_bits;
          slot_n    = slot + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= '0;
      staging   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      staging   <= staging_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      frame_err <= frame_err_n;
    end
  end

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16; expected words are queued at stimulus time and popped on out_valid.
module tb_tdm_demux16;
  import tdm_pkg::*;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             din       = 1'b0;
  logic             din_valid = 1'b0;
  logic             sync      = 1'b0;
  logic             mode      = 1'b0;
  logic [0:SEL_W-1] sel_in    = '0;
  logic [0:SLOTS-1] out;
  logic             out_valid;
  logic [0:SEL_W-1] slot;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  logic [0:SLOTS-1] exp_q[$];

  always #5 clk = ~clk;

  tdm_demux16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .mode      (mode),
    .sel_in    (sel_in),
    .out       (out),
    .out_valid (out_valid),
    .slot      (slot),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic dv, input logic sy, input logic d, input logic md,
                      input logic [0:SEL_W-1] sl, input logic exp_ov, input logic exp_fe,
                      input string tag);
    logic [0:SLOTS-1] w;
    din_valid = dv;
    sync      = sy;
    din       = d;
    mode      = md;
    sel_in    = sl;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(exp_fe));
    if (out_valid) begin
      chk({tag, ".word_expected"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk({tag, ".out"}, 32'(out), 32'(w));
      end
    end
  endtask

  task automatic send(input logic [0:SLOTS-1] word, input int from, input int to,
                      input logic first_sync, input string tag);
    for (int k = from; k <= to; k++)
      step(1'b1, first_sync && (k == from), word[k], 1'b0, '0, k == SLOTS-1, 1'b0, tag);
  endtask

  task automatic idle(input logic md, input string tag);
    step(1'b0, 1'b0, 1'b0, md, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [0:SLOTS-1] w1, w2, w3, w4, e;
    logic [0:SEL_W-1] s;
    w1 = 16'b1010_0000_1111_0001;
    w2 = 16'h5A3C;
    w3 = 16'hC3E6;
    w4 = 16'h9F14;

    // Reset state
    #2;
    chk("reset.out", 32'(out), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    chk("reset.slot", 32'(slot), 32'd0);
    #10 rst_n = 1'b1;

    // Plain auto frame
    exp_q.push_back(w1);
    send(w1, 0, 15, 1'b1, "frame1");
    chk("frame1.slot", 32'(slot), 32'd0);
    idle(1'b0, "frame1_hold");
    chk("frame1_hold.out", 32'(out), 32'(w1));

    // Gapped frame: 3 idle cycles between slots 7 and 8
    send(w1, 0, 7, 1'b1, "gap_a");
    chk("gap.slot8", 32'(slot), 32'd8);
    for (int g = 0; g < 3; g++) idle(1'b0, "gap_idle");
    chk("gap.slot_held", 32'(slot), 32'd8);
    exp_q.push_back(w1);
    send(w1, 8, 15, 1'b0, "gap_b");

    // Early sync at slot 5
    send(w2, 0, 4, 1'b1, "early_a");
    step(1'b1, 1'b1, w3[0], 1'b0, '0, 1'b0, 1'b1, "early_sync");
    chk("early.slot", 32'(slot), 32'd1);
    chk("early.out_held", 32'(out), 32'(w1));
    exp_q.push_back(w3);
    send(w3, 1, 15, 1'b0, "early_b");
    chk("early.slot_wrap", 32'(slot), 32'd0);

    // Missing sync after a completed frame, then unsynced bits dropped in HUNT
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, "missing_sync");
    chk("missing.slot", 32'(slot), 32'd0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, k[0], 1'b0, '0, 1'b0, 1'b0, "hunt_drop");
    chk("missing.out_held", 32'(out), 32'(w3));

    // Mode 0->1 mid-frame: partial frame discarded silently
    send(w2, 0, 3, 1'b1, "switch_a");
    idle(1'b1, "switch_to_addr");
    chk("switch.slot", 32'(slot), 32'd0);

    // Addressed mode: clear every bit, then set 0, 7, 15
    e = w3;
    for (int k = 0; k < SLOTS; k++) begin
      e[k] = 1'b0;
      exp_q.push_back(e);
      step(1'b1, 1'b0, 1'b0, 1'b1, SEL_W'(k), 1'b1, 1'b0, "addr_clear");
    end
    idle(1'b1, "addr_idle");
    s = 4'b0000;
    e[0] = 1'b1;
    exp_q.push_back(e);
    step(1'b1, 1'b1, 1'b1, 1'b1, s, 1'b1, 1'b0, "addr_w0");
    s = 4'b0111;
    e[7] = 1'b1;
    exp_q.push_back(e);
    step(1'b1, 1'b0, 1'b1, 1'b1, s, 1'b1, 1'b0, "addr_w7");
    s = 4'b1111;
    e[15] = 1'b1;
    exp_q.push_back(e);
    step(1'b1, 1'b0, 1'b1, 1'b1, s, 1'b1, 1'b0, "addr_w15");
    chk("addr.final", 32'(out), 32'(16'b1000_0001_0000_0001));
    chk("addr.slot", 32'(slot), 32'd0);

    // Mode 1->0 lands in HUNT: an unsynced bit is dropped without error
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "hunt_after_addr");

    // Async reset at slot 9
    send(w4, 0, 8, 1'b1, "rst_a");
    chk("rst.slot9", 32'(slot), 32'd9);
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out", 32'(out), 32'd0);
    chk("rst_mid.slot", 32'(slot), 32'd0);
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "hunt_after_reset");
    exp_q.push_back(w4);
    send(w4, 0, 15, 1'b1, "rst_frame");
    chk("rst_frame.slot", 32'(slot), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side counterpart of the 16:1 gate-level mux path.
- A transmitter scans a 16-bit word through the mux, sel counting 0..15, producing one bit per slot. This block reassembles the serial slot stream into a 16-bit parallel word.
- Also supports an addressed mode: a single bit is written to the output position given by an explicit select, as a registered 1:16 demux.
- Sits between the serial link and parallel consumer logic.

Parameters:
- SLOTS, 16, number of slots/output bits; power of two.
- SEL_W, 4, select/slot index width; equals log2(SLOTS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial slot bit.
- din_valid  input  1  din is meaningful this cycle.
- sync  input  1  qualifies din as slot 0 of a frame; ignored when din_valid=0.
- mode  input  1  0 = auto-scan (TDM frame), 1 = addressed.
- sel_in  input  [0:SEL_W-1]  target bit index in addressed mode; sel_in[0] is the MSB.
- out  output  [0:SLOTS-1]  registered word; out[k] corresponds to mux input in[k] (sel=k).
- out_valid  output  1  one-cycle pulse: out updated.
- slot  output  [0:SEL_W-1]  next expected slot index.
- frame_err  output  1  one-cycle pulse on framing error.

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, out_valid=0, frame_err=0, slot=0, staging=0, state=HUNT. Reset asserted mid-frame discards the partial frame.
- States: HUNT (waiting for sync), RUN (collecting a frame). Internal staging register is SLOTS bits wide.
- out_valid and frame_err default to 0 every cycle; each is a single-cycle pulse.

Auto-scan mode (mode=0):
- HUNT, din_valid & sync: staging cleared, then staging[0]=din; slot=1; go to RUN.
- HUNT, din_valid & !sync: bit dropped; stay in HUNT; no error.
- RUN, din_valid & !sync & slot!=0: staging[slot]=din; slot=slot+1.
- Frame complete, at slot==SLOTS-1 with din_valid:
  - out takes staging with bit SLOTS-1 replaced by din, visible the cycle after the last bit.
  - out_valid=1 for that cycle.
  - slot wraps to 0; stay in RUN.
- RUN, slot==0, din_valid & sync: new frame starts, same as the HUNT case.
- RUN, slot==0, din_valid & !sync: frame_err=1; go to HUNT; bit dropped.
- RUN, slot!=0, din_valid & sync (early sync):
  - frame_err=1.
  - Partial frame discarded; this bit becomes slot 0 of a new frame (staging cleared, staging[0]=din, slot=1).
  - out is unchanged.
- din_valid=0: no state change; gaps between slots are allowed.

Addressed mode (mode=1):
- din_valid: out[sel_in]=din; all other out bits hold; out_valid=1 the next cycle.
- sync is ignored. state=HUNT, slot=0, staging cleared.

Mode changes and out register:
- mode change 0→1 mid-frame: partial frame discarded, no frame_err.
- mode change 1→0: start in HUNT.
- out holds its value between updates; an auto-mode completion overwrites all bits.

Latency:
- Auto mode: 1 cycle from the last slot's din_valid edge to out/out_valid.
- Addressed mode: 1 cycle.

Decomposition:
- Shared package (tdm_pkg):
  - SLOTS and SEL_W constants.
  - State encoding: HUNT=1'b0, RUN=1'b1.
  - MSB-first index convention, [0:N-1] with bit 0 = sel 0.
- Natural sub-module: dec4to16_onehot. Combinational select-to-one-hot write-enable decoder, fed by slot or sel_in through a mode mux. It is the inverse of the 4:1/16:1 mux tree.

Test Plan:
- Reset then auto frame:
  - Stimulus: mode=0; 16 consecutive valid bits of 16'b1010_0000_1111_0001; sync on the first bit.
  - Required: out=16'b1010000011110001 with out_valid=1 exactly one cycle after bit 15; slot=0; frame_err never asserted.
- Gapped frame:
  - Stimulus: same word with din_valid=0 for 3 cycles between slots 7 and 8.
  - Required: identical out; out_valid only after slot 15.
- Early sync:
  - Stimulus: sync re-asserted at slot 5.
  - Required: frame_err pulse that cycle; slot=1 next; out unchanged until the new frame completes 16 bits later.
- Missing sync:
  - Stimulus: after a completed frame, next valid bit has sync=0.
  - Required: frame_err=1; state HUNT; subsequent unsynced bits ignored; no out_valid.
- Addressed mode:
  - Stimulus: mode=1; write din=1 at sel_in=4'b0000, 4'b0111, 4'b1111.
  - Required: out=16'b1000000100000001; out_valid pulse after each write.
- Async reset mid-frame:
  - Stimulus: rst_n low for half a cycle at slot 9.
  - Required: out=0, slot=0, state HUNT immediately; a following full frame is captured correctly.
